// File: rtl/counter_pkg.sv
// Shared constants for the counter bank: channel direction and terminal-count behaviour.
package counter_pkg;

  localparam logic DIR_UP      = 1'b0;
  localparam logic DIR_DOWN    = 1'b1;

  localparam logic MODE_WRAP   = 1'b0;
  localparam logic MODE_RELOAD = 1'b1;

endpackage

// File: rtl/counter_chan.sv
// One counter channel: up/down count on the shared tick, with wrap or auto-reload
// at terminal count, a one-cycle carry pulse and a sticky irq flag.
module counter_chan
  import counter_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          en,
  input  logic          dir,
  input  logic          reload_en,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          irq_clr,
  output logic [DW-1:0] count,
  output logic          carry,
  output logic          zero,
  output logic          irq
);

  localparam logic [DW-1:0] ALL_ONES = '1;

  logic [DW-1:0] reload_value;
  logic [DW-1:0] next_count;
  logic          advance;
  logic          terminal;
  logic          term_event;

  // A load in the same cycle as a tick wins, so the channel never advances then.
  assign advance    = tick & en & ~load;
  assign terminal   = (dir == DIR_UP) ? (count == ALL_ONES) : (count == '0);
  assign term_event = advance & terminal;
  assign zero       = (count == '0);

  always_comb begin
    // NOTE: next_count is defaulted before any branch so every path assigns it and no latch is inferred.
    next_count = count;
    if (load) begin
      next_count = load_data;
    end else if (advance) begin
      if (terminal) begin
        if (reload_en == MODE_RELOAD) next_count = reload_value;
        else                          next_count = (dir == DIR_UP) ? '0 : ALL_ONES;
      end else begin
        next_count = (dir == DIR_UP) ? count + 1'b1 : count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      count        <= '0;
      // NOTE: the reload register is storage, but it is cleared on reset so a reload before any load yields 0.
      reload_value <= '0;
      carry        <= 1'b0;
      irq          <= 1'b0;
    end else begin
      count <= next_count;
      if (load) reload_value <= load_data;
      carry <= term_event;
      // A terminal event outranks a clear arriving in the same cycle.
      if (term_event)   irq <= 1'b1;
      else if (irq_clr) irq <= 1'b0;
    end
  end

endmodule

// File: rtl/counter_bank.sv
// Bank of CH independent counters advanced by one shared programmable prescaler tick.
module counter_bank
  import counter_pkg::*;
#(
  parameter int DW = 32,
  parameter int CH = 4,
  parameter int PW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PW-1:0]    prescale,
  input  logic [CH-1:0]    en,
  input  logic [CH-1:0]    dir,
  input  logic [CH-1:0]    reload_en,
  input  logic [CH-1:0]    load,
  input  logic [CH*DW-1:0] load_data,
  input  logic [CH-1:0]    irq_clr,
  output logic [CH*DW-1:0] count,
  output logic [CH-1:0]    carry,
  output logic [CH-1:0]    zero,
  output logic [CH-1:0]    irq
);

  logic [PW-1:0] p;
  logic          tick;

  // Using >= rather than == lets a prescale lowered below p tick on the very next cycle.
  assign tick = (p >= prescale);

  always_ff @(posedge clk) begin
    if (reset)     p <= '0;
    else if (tick) p <= '0;
    else           p <= p + 1'b1;
  end

  for (genvar i = 0; i < CH; i++) begin : g_chan
    counter_chan #(
      .DW(DW)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .en        (en[i]),
      .dir       (dir[i]),
      .reload_en (reload_en[i]),
      .load      (load[i]),
      .load_data (load_data[i*DW +: DW]),
      .irq_clr   (irq_clr[i]),
      .count     (count[i*DW +: DW]),
      .carry     (carry[i]),
      .zero      (zero[i]),
      .irq       (irq[i])
    );
  end

endmodule

// File: tb/tb_counter_bank.sv
// Self-checking bench for counter_bank: directed scenarios plus randomized traffic
// compared every cycle against an arithmetic reference model.
module tb_counter_bank;

  localparam int DW  = 8;
  localparam int CH  = 4;
  localparam int PW  = 4;
  localparam int MAX = (1 << DW) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [PW-1:0]    prescale;
  logic [CH-1:0]    en, dir, reload_en, load, irq_clr;
  logic [CH*DW-1:0] load_data;
  logic [CH*DW-1:0] count;
  logic [CH-1:0]    carry, zero, irq;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_p;
  int m_count [CH];
  int m_reload[CH];
  bit m_carry [CH];
  bit m_irq   [CH];

  counter_bank #(.DW(DW), .CH(CH), .PW(PW)) dut (
    .clk       (clk),
    .reset     (reset),
    .prescale  (prescale),
    .en        (en),
    .dir       (dir),
    .reload_en (reload_en),
    .load      (load),
    .load_data (load_data),
    .irq_clr   (irq_clr),
    .count     (count),
    .carry     (carry),
    .zero      (zero),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int slice(input int i);
    logic [DW-1:0] v;
    v = count[i*DW +: DW];
    return int'(v);
  endfunction

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    bit tick;
    int ld;
    bit term;
    if (reset) begin
      m_p = 0;
      for (int i = 0; i < CH; i++) begin
        m_count[i] = 0; m_reload[i] = 0; m_carry[i] = 0; m_irq[i] = 0;
      end
      return;
    end
    tick = (m_p >= int'(prescale));
    m_p  = tick ? 0 : m_p + 1;
    for (int i = 0; i < CH; i++) begin
      term = 0;
      ld   = int'(load_data[i*DW +: DW]);
      if (load[i]) begin
        m_count[i]  = ld;
        m_reload[i] = ld;
      end else if (tick && en[i]) begin
        if (!dir[i]) begin
          term = (m_count[i] == MAX);
          m_count[i] = term ? (reload_en[i] ? m_reload[i] : 0) : m_count[i] + 1;
        end else begin
          term = (m_count[i] == 0);
          m_count[i] = term ? (reload_en[i] ? m_reload[i] : MAX) : m_count[i] - 1;
        end
      end
      m_carry[i] = term;
      if (term)            m_irq[i] = 1;
      else if (irq_clr[i]) m_irq[i] = 0;
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < CH; i++) begin
      check($sformatf("count[%0d]", i), 64'(slice(i)), 64'(m_count[i]));
      check($sformatf("carry[%0d]", i), 64'(carry[i]), 64'(m_carry[i]));
      check($sformatf("irq[%0d]",   i), 64'(irq[i]),   64'(m_irq[i]));
      check($sformatf("zero[%0d]",  i), 64'(zero[i]),  64'(m_count[i] == 0));
    end
  endtask

  // Inputs change only 1 time unit after the edge, well away from sampling.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic set_load(input int ch, input int value);
    logic [DW-1:0] v;
    v = DW'(value);
    load[ch] = 1'b1;
    load_data[ch*DW +: DW] = v;
  endtask

  initial begin
    reset = 1'b1; prescale = '0; en = '0; dir = '0; reload_en = '0;
    load = '0; load_data = '0; irq_clr = '0;
    for (int i = 0; i < CH; i++) begin
      m_count[i] = 0; m_reload[i] = 0; m_carry[i] = 0; m_irq[i] = 0;
    end
    m_p = 0;
    #1;
    cycle();
    cycle();
    check("reset_zero_all", 64'(zero), 64'({CH{1'b1}}));
    check("reset_count_all", 64'(count), 64'(0));
    reset = 1'b0;

    // Ch0 up, wrap, crossing terminal from 0xFE
    set_load(0, 8'hFE);
    cycle();
    load = '0; en[0] = 1'b1;
    cycle();
    check("up_ff", 64'(slice(0)), 64'h00FF);
    check("up_ff_carry", 64'(carry[0]), 64'(0));
    cycle();
    check("wrap_00", 64'(slice(0)), 64'h0000);
    check("wrap_carry", 64'(carry[0]), 64'(1));
    check("wrap_irq", 64'(irq[0]), 64'(1));
    cycle();
    check("carry_one_cycle", 64'(carry[0]), 64'(0));
    en[0] = 1'b0;

    // Ch1 down with auto-reload from 3
    dir[1] = 1'b1; reload_en[1] = 1'b1;
    set_load(1, 3);
    cycle();
    load = '0; en[1] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      int exp_v;
      exp_v = (k % 4 == 3) ? 3 : 2 - (k % 4);
      cycle();
      check($sformatf("reload_seq%0d", k), 64'(slice(1)), 64'(exp_v));
      check($sformatf("reload_carry%0d", k), 64'(carry[1]), 64'(k % 4 == 3));
      check($sformatf("reload_zero%0d", k), 64'(zero[1]), 64'(k % 4 == 2));
    end
    en[1] = 1'b0;

    // irq_clr alone clears; irq_clr coinciding with terminal leaves irq set
    irq_clr[0] = 1'b1;
    cycle();
    check("irq_clr_alone", 64'(irq[0]), 64'(0));
    irq_clr[0] = 1'b0;
    set_load(0, 8'hFF);
    cycle();
    load = '0; en[0] = 1'b1; irq_clr[0] = 1'b1;
    cycle();
    check("irq_clr_vs_term", 64'(irq[0]), 64'(1));
    en[0] = 1'b0;
    cycle();
    check("irq_clr_next", 64'(irq[0]), 64'(0));
    irq_clr[0] = 1'b0;

    // Load and tick together at 0xFF: load wins, no carry
    set_load(0, 8'hFF);
    cycle();
    set_load(0, 8'h55); en[0] = 1'b1;
    cycle();
    check("load_prio_count", 64'(slice(0)), 64'h0055);
    check("load_prio_carry", 64'(carry[0]), 64'(0));
    load = '0; en[0] = 1'b0;

    // Reset mid-count with irq set and carry pending
    set_load(2, 8'hFF);
    cycle();
    load = '0; en[2] = 1'b1;
    cycle();
    check("pre_reset_irq", 64'(irq[2]), 64'(1));
    reset = 1'b1; set_load(3, 8'h12); irq_clr = '1;
    cycle();
    check("rst_counts", 64'(count), 64'(0));
    check("rst_irq", 64'(irq), 64'(0));
    check("rst_carry", 64'(carry), 64'(0));
    check("rst_zero", 64'(zero), 64'({CH{1'b1}}));
    reset = 1'b0; load = '0; irq_clr = '0; en = '0;

    // Prescale of 3: one increment every 4 cycles
    prescale = 4'd3; dir[0] = 1'b0; en[0] = 1'b1;
    for (int k = 0; k < 40; k++) cycle();
    check("prescale3_40cyc", 64'(slice(0)), 64'(10));
    en = '0;

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 15) == 0) prescale = PW'($urandom_range(0, 6));
      en        = CH'($urandom);
      dir       = CH'($urandom);
      reload_en = CH'($urandom);
      load      = CH'($urandom & $urandom & $urandom);
      load_data = (CH*DW)'($urandom);
      for (int i = 0; i < CH; i++)
        if ($urandom_range(0, 3) == 0) load_data[i*DW +: DW] = ($urandom_range(0, 1) != 0) ? 8'hFE : 8'h01;
      irq_clr   = CH'($urandom & $urandom);
      reset     = ($urandom_range(0, 79) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/counter_bank.md
COUNTER_BANK -- requirements
Module: counter_bank

Interface
REQ-001 SHALL have parameter DW, default 32, meaning counter width per channel in bits.
REQ-002 SHALL have parameter CH, default 4, meaning number of independent counter channels.
REQ-003 SHALL have parameter PW, default 8, meaning shared prescaler width in bits.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port prescale  input  PW  tick period minus one.
REQ-007 SHALL have port en  input  CH  per-channel count enable.
REQ-008 SHALL have port dir  input  CH  per-channel direction: 0 = up, 1 = down.
REQ-009 SHALL have port reload_en  input  CH  per-channel select: 1 = auto-reload on terminal, 0 = wrap.
REQ-010 SHALL have port load  input  CH  per-channel load strobe.
REQ-011 SHALL have port load_data  input  CH*DW  packed load values; channel i at [i*DW +: DW].
REQ-012 SHALL have port irq_clr  input  CH  per-channel sticky-flag clear.
REQ-013 SHALL have port count  output  CH*DW  packed current counts.
REQ-014 SHALL have port carry  output  CH  one-cycle terminal-event pulse, registered.
REQ-015 SHALL have port zero  output  CH  combinational flag: count == 0.
REQ-016 SHALL have port irq  output  CH  sticky terminal flag, registered.

Function
REQ-017 Prescaler SHALL be a PW-bit counter p; tick = (p >= prescale); on tick p <= 0, else p <= p+1.
REQ-018 prescale = 0 SHALL produce tick every cycle; a prescale lowered below p SHALL tick on the next cycle.
REQ-019 Channel advance SHALL occur only in a cycle with tick & en[i] & !load[i].
REQ-020 Terminal condition SHALL be count == all-ones when dir = 0, and count == 0 when dir = 1.
REQ-021 Non-terminal advance SHALL set count to count+1 (up) or count-1 (down), modulo 2^DW.
REQ-022 Terminal advance with reload_en = 0 SHALL wrap: all-ones to 0 (up), 0 to all-ones (down).
REQ-023 Terminal advance with reload_en = 1 SHALL set count to the channel's reload register.
REQ-024 Terminal advance SHALL assert carry[i] for exactly the following cycle and set irq[i].
REQ-025 load[i] SHALL write load_data slice to both count and the reload register next cycle, clear carry[i], and take priority over advance.
REQ-026 irq[i] SHALL clear on irq_clr[i]; simultaneous terminal event and irq_clr SHALL leave irq set.
REQ-027 carry[i] SHALL be 0 in any cycle not following a terminal advance.
REQ-028 dir, reload_en and en SHALL be sampled per cycle; changing them mid-count SHALL take effect on the next tick.
REQ-029 Channels SHALL be fully independent except for the shared tick.

Reset
REQ-030 reset SHALL set p, every count, every reload register, carry and irq to 0, giving zero = all-ones.
REQ-031 reset SHALL override load, tick and irq_clr in the same cycle.
REQ-032 Reset asserted mid-count SHALL discard the pending carry and restart the prescale period from p = 0.

Structure
REQ-033 Package counter_pkg SHALL hold direction constants DIR_UP = 0 and DIR_DOWN = 1, and reload constants MODE_WRAP = 0 and MODE_RELOAD = 1.
REQ-034 Per-channel logic SHALL be a sub-module counter_chan, instantiated CH times in a generate loop; the prescaler SHALL live in counter_bank.

Verification
REQ-035 DW=8, prescale=0, ch0 up, load 0xFE, en -> counts 0xFF, then 0x00 with carry[0] pulse and irq[0]=1.
REQ-036 ch1 down, reload_en=1, load 0x03 -> 3,2,1,0,3 sequence; carry[1] pulses once per period; zero[1] high one tick.
REQ-037 prescale=3, ch0 up from 0 -> count increments every 4th cycle; after 40 cycles count = 10.
REQ-038 load and tick in the same cycle at count 0xFF up -> count = load_data, no carry.
REQ-039 irq_clr in the same cycle as terminal event -> irq remains 1; irq_clr alone next cycle -> irq = 0.
REQ-040 reset asserted mid-count with irq set -> all counts 0, irq 0, carry 0, zero all-ones next cycle.
